// File: rtl/cellrv32_board_sysctl_if.sv
// Board-side signal bundle of the CELLRV32 system controller: raw buttons and
// core GPIO in, core reset, debounced buttons and LED drive out.
interface cellrv32_board_sysctl_if #(
   parameter int NUM_BTN = 4,
   parameter int NUM_LED = 18
);
   logic [NUM_BTN-1:0] btn_i;
   logic [NUM_LED-1:0] gpio_i;
   logic               sys_rstn_o;
   logic [NUM_BTN-1:0] btn_o;
   logic [NUM_BTN-1:0] btn_rise_o;
   logic [NUM_LED-1:0] led_o;

   modport master (
      output btn_i, gpio_i,
      input  sys_rstn_o, btn_o, btn_rise_o, led_o
   );

   modport slave (
      input  btn_i, gpio_i,
      output sys_rstn_o, btn_o, btn_rise_o, led_o
   );
endinterface

// File: rtl/cellrv32_board_sysctl.sv
// Board-level system controller: stretched core reset, button debounce with
// press pulses, optional core-reset button and heartbeat/GPIO LED mux.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_RESET   | board reset just released, waiting for synchronised release
// ST_STRETCH | core held in reset for RST_STRETCH_CYCLES cycles
// ST_RUN     | core running, LEDs follow GPIO
// ST_HOLD    | reset button pressed, core held until the button is let go
module cellrv32_board_sysctl #(
   parameter int NUM_BTN            = 4,
   parameter int NUM_LED            = 18,
   parameter int BTN_ACTIVE_LOW     = 1,
   parameter int DEBOUNCE_CYCLES    = 500000,
   parameter int RST_STRETCH_CYCLES = 1024,
   parameter int HB_HALF_CYCLES     = 25000000,
   parameter int RST_BTN            = 0,
   parameter int LED_HB_EN          = 1
) (
   input logic                    clk_i,
   input logic                    rstn_i,
   cellrv32_board_sysctl_if.slave bus
);

   localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int RS_W = (RST_STRETCH_CYCLES > 1) ? $clog2(RST_STRETCH_CYCLES) : 1;
   localparam int HB_W = (HB_HALF_CYCLES > 1) ? $clog2(HB_HALF_CYCLES) : 1;

   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [RS_W-1:0] RS_LAST = RS_W'(RST_STRETCH_CYCLES - 1);
   localparam logic [HB_W-1:0] HB_LAST = HB_W'(HB_HALF_CYCLES - 1);

   localparam bit RST_BTN_EN = (RST_BTN >= 0) && (RST_BTN < NUM_BTN);
   localparam int RST_IDX    = RST_BTN_EN ? RST_BTN : 0;

   // Synchroniser flops idle at the released level so reset does not look like a press.
   localparam logic [NUM_BTN-1:0] BTN_IDLE = (BTN_ACTIVE_LOW != 0) ? '1 : '0;

   typedef enum logic [1:0] {
      ST_RESET   = 2'd0,
      ST_STRETCH = 2'd1,
      ST_RUN     = 2'd2,
      ST_HOLD    = 2'd3
   } state_t;

   state_t             state;
   logic [RS_W-1:0]    rs_cnt;
   logic               sys_rstn_q;
   logic [1:0]         rst_sync;
   logic [NUM_BTN-1:0] btn_meta;
   logic [NUM_BTN-1:0] btn_sync;
   logic [NUM_BTN-1:0] btn_norm;
   logic [NUM_BTN-1:0] btn_q;
   logic [NUM_BTN-1:0] rise_q;
   logic [HB_W-1:0]    hb_cnt;
   logic               hb;
   logic [NUM_LED-1:0] led_next;
   logic [NUM_LED-1:0] led_q;

   // Board reset: asynchronous assert, two-flop synchronous release.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) rst_sync <= 2'b00;
      else         rst_sync <= {rst_sync[0], 1'b1};
   end

   // Two-flop synchroniser on the raw button pins.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         btn_meta <= BTN_IDLE;
         btn_sync <= BTN_IDLE;
      end else begin
         btn_meta <= bus.btn_i;
         btn_sync <= btn_meta;
      end
   end

   assign btn_norm = (BTN_ACTIVE_LOW != 0) ? ~btn_sync : btn_sync;

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
      logic [DB_W-1:0] cnt;
      logic            lvl;
      logic            rise;

      // Accept a new level only after it has differed from the current one for DEBOUNCE_CYCLES cycles.
      always_ff @(posedge clk_i or negedge rstn_i) begin
         if (!rstn_i) begin
            cnt  <= '0;
            lvl  <= 1'b0;
            rise <= 1'b0;
         end else begin
            rise <= 1'b0;
            if (btn_norm[i] == lvl) begin
               cnt <= '0;
            end else if (cnt == DB_LAST) begin
               cnt  <= '0;
               lvl  <= btn_norm[i];
               rise <= btn_norm[i];
            end else begin
               cnt <= cnt + DB_W'(1);
            end
         end
      end

      assign btn_q[i]  = lvl;
      assign rise_q[i] = rise;
   end

   // Core reset sequencer; sys_rstn_q is set on the same edge the FSM enters RUN.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state      <= ST_RESET;
         rs_cnt     <= '0;
         sys_rstn_q <= 1'b0;
      end else begin
         case (state)
            ST_RESET: begin
               if (rst_sync[1]) state <= ST_STRETCH;
            end
            ST_STRETCH: begin
               if (rs_cnt == RS_LAST) begin
                  rs_cnt     <= '0;
                  state      <= ST_RUN;
                  sys_rstn_q <= 1'b1;
               end else begin
                  rs_cnt <= rs_cnt + RS_W'(1);
               end
            end
            ST_RUN: begin
               if (RST_BTN_EN && rise_q[RST_IDX]) begin
                  state      <= ST_HOLD;
                  sys_rstn_q <= 1'b0;
               end
            end
            ST_HOLD: begin
               if (!btn_q[RST_IDX]) state <= ST_STRETCH;
            end
            default: begin
               state      <= ST_RESET;
               sys_rstn_q <= 1'b0;
            end
         endcase
      end
   end

   // Free-running heartbeat, untouched by button resets.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         hb_cnt <= '0;
         hb     <= 1'b0;
      end else if (hb_cnt == HB_LAST) begin
         hb_cnt <= '0;
         hb     <= ~hb;
      end else begin
         hb_cnt <= hb_cnt + HB_W'(1);
      end
   end

   // LED source: GPIO (optionally with heartbeat on the MSB) in RUN, heartbeat on bit 0 otherwise.
   always_comb begin
      led_next = '0;
      if (state == ST_RUN) begin
         led_next = bus.gpio_i;
         if (LED_HB_EN != 0) led_next[NUM_LED-1] = hb;
      end else begin
         led_next[0] = hb;
      end
   end

   // Registered LED drive.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) led_q <= '0;
      else         led_q <= led_next;
   end

   assign bus.sys_rstn_o = sys_rstn_q;
   assign bus.btn_o      = btn_q;
   assign bus.btn_rise_o = rise_q;
   assign bus.led_o      = led_q;

endmodule
